iack_ctrl: RTL

IACK_CTRL -- requirements
Module: iack_ctrl

---
 rtl/raven_bus_pkg.sv | 21 ++
 rtl/iack_ctrl_if.sv | 22 ++
 rtl/sync2.sv | 26 ++
 rtl/iack_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/raven_bus_pkg.sv
// rtl/raven_bus_pkg.sv - shared IACK state encoding and 68000 IACK bus-cycle match constants
package raven_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    WAIT_DTACK,
    AUTOVEC,
    FAULT,
    DONE
  } iack_state_e;

  localparam logic [2:0] IACK_FC      = 3'b111;
  localparam logic [3:0] IACK_ADDR_HI = 4'hF;

  function automatic logic is_iack_cycle(input logic as_n_s, input logic [2:0] fc,
                                         input logic [3:0] addr_hi);
    return !as_n_s && (fc == IACK_FC) && (addr_hi == IACK_ADDR_HI);
  endfunction

endpackage

// File: rtl/iack_ctrl_if.sv
// rtl/iack_ctrl_if.sv - CPU/DUART side signals of the IACK controller
interface iack_ctrl_if;
  logic       as_n;
  logic [2:0] fc;
  logic [3:0] addr_hi;
  logic [2:0] addr_lvl;
  logic       duart_dtack_n;
  logic       duart_iack_n;
  logic       vpa_n;
  logic       berr_n;
  logic       iack_busy;

  modport slave (
    input  as_n, fc, addr_hi, addr_lvl, duart_dtack_n,
    output duart_iack_n, vpa_n, berr_n, iack_busy
  );

  modport master (
    output as_n, fc, addr_hi, addr_lvl, duart_dtack_n,
    input  duart_iack_n, vpa_n, berr_n, iack_busy
  );
endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser with asynchronous reset to a configurable idle level
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/iack_ctrl.sv
// rtl/iack_ctrl.sv - 68000 interrupt-acknowledge controller (DUART vector, autovector or bus error)
// IACK_AUTOVEC_FALLBACK_EN: a DUART DTACK timeout falls back to autovector instead of bus error.
module iack_ctrl
  import raven_bus_pkg::*;
#(
  parameter int DUART_LEVEL    = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic        clk,
  input logic        reset,
  iack_ctrl_if.slave bus
);

  localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] DUART_LVL = 3'(DUART_LEVEL);

  logic        as_s;
  logic        dtack_s;
  iack_state_e state_q, state_d;
  logic [2:0]  lvl_q, lvl_d;
  logic [2:0]  fc_q, fc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  settle_q, settle_d;
  logic        armed_q, armed_d;
  logic        iack_n_q, iack_n_d;
  logic        vpa_n_q, vpa_n_d;
  logic        berr_n_q, berr_n_d;
  logic        busy_q, busy_d;

  sync2 #(.RESET_VAL(1'b1)) u_sync_as (
    .clk   (clk),
    .reset (reset),
    .d     (bus.as_n),
    .q     (as_s)
  );

  sync2 #(.RESET_VAL(1'b1)) u_sync_dtack (
    .clk   (clk),
    .reset (reset),
    .d     (bus.duart_dtack_n),
    .q     (dtack_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      lvl_q    <= '0;
      fc_q     <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      armed_q  <= 1'b0;
      iack_n_q <= 1'b1;
      vpa_n_q  <= 1'b1;
      berr_n_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lvl_q    <= lvl_d;
      fc_q     <= fc_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      armed_q  <= armed_d;
      iack_n_q <= iack_n_d;
      vpa_n_q  <= vpa_n_d;
      berr_n_q <= berr_n_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lvl_d    = lvl_q;
    fc_d     = fc_q;
    cnt_d    = cnt_q;
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    // The synchronisers reset high, so as_n is only trusted once they have flushed; a
    // cycle already in flight at reset release must end (as_n high) before we re-arm.
    armed_d  = armed_q | ((settle_q == 2'd2) && as_s);

    case (state_q)
      IDLE: begin
        if (armed_q && is_iack_cycle(as_s, bus.fc, bus.addr_hi)) begin
          state_d = DECODE;
          lvl_d   = bus.addr_lvl;
          fc_d    = bus.fc;
        end
      end
      DECODE: begin
        if (as_s) begin
          state_d = IDLE;
        end else if ((fc_q != IACK_FC) || (lvl_q == 3'd0)) begin
          state_d = FAULT;
        end else if (lvl_q == DUART_LVL) begin
          state_d = WAIT_DTACK;
          cnt_d   = '0;
        end else begin
          state_d = AUTOVEC;
        end
      end
      WAIT_DTACK: begin
        if (as_s) begin
          state_d = IDLE;
        end else if (!dtack_s) begin
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
`ifdef IACK_AUTOVEC_FALLBACK_EN
          state_d = AUTOVEC;
`else
          state_d = FAULT;
`endif
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      AUTOVEC, FAULT, DONE: begin
        if (as_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes decode from the next state so each one is a clean flop output.
    iack_n_d = !((state_d == WAIT_DTACK) || (state_d == DONE));
    vpa_n_d  = (state_d != AUTOVEC);
    berr_n_d = (state_d != FAULT);
    busy_d   = (state_d != IDLE);
  end

  assign bus.duart_iack_n = iack_n_q;
  assign bus.vpa_n        = vpa_n_q;
  assign bus.berr_n       = berr_n_q;
  assign bus.iack_busy    = busy_q;

endmodule
